// File: rtl/jesd204_fec_block_feeder.sv
// Frames a 64-bit payload stream into 2048-bit JESD204C FEC blocks, sequences the
// external LFSR through clear/shift/drain, and returns the 26-bit remainder as parity.
module jesd204_fec_block_feeder #(
  parameter int DATA_WIDTH      = 64,
  parameter int WORDS_PER_BLOCK = 32,
  parameter int LFSR_WIDTH      = 26
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sob,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [LFSR_WIDTH-1:0] par_data,
  output logic                  par_valid,
  input  logic                  par_ready,
  output logic                  sob_err,
  output logic                  lfsr_rst,
  output logic                  lfsr_shift_en,
  output logic [5:0]            lfsr_shift_cnt,
  output logic [DATA_WIDTH-1:0] lfsr_data_in,
  input  logic [LFSR_WIDTH-1:0] lfsr_shift_reg
);
  localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);

  localparam logic [2:0] S_CLEAR  = 3'd0;
  localparam logic [2:0] S_SHIFT  = 3'd1;
  localparam logic [2:0] S_DRAIN1 = 3'd2;
  localparam logic [2:0] S_DRAIN2 = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]            state;
  logic [CNT_W-1:0]      word_cnt;
  logic [DATA_WIDTH-1:0] data_rev;
  logic                  accept, first_word, bad_start, bad_mid, good;

  // LFSR consumes data_in[0] first, while in_data[MSb] is first in time.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_rev
    assign data_rev[i] = in_data[DATA_WIDTH-1-i];
  end

  assign lfsr_shift_cnt = 6'(DATA_WIDTH - 1);
  assign in_ready       = (state == S_SHIFT);
  assign par_valid      = (state == S_DONE);
  assign lfsr_rst       = (state == S_CLEAR);

  assign accept     = in_valid & in_ready;
  assign first_word = (word_cnt == '0);
  assign bad_start  = accept & first_word & ~in_sob;
  assign bad_mid    = accept & ~first_word & in_sob;
  assign good       = accept & ~bad_start & ~bad_mid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_CLEAR;
      word_cnt      <= '0;
      par_data      <= '0;
      sob_err       <= 1'b0;
      lfsr_shift_en <= 1'b0;
      lfsr_data_in  <= '0;
    end else begin
      sob_err       <= bad_start | bad_mid;
      lfsr_shift_en <= good;
      if (good) lfsr_data_in <= data_rev;
      case (state)
        S_CLEAR: begin
          state    <= S_SHIFT;
          word_cnt <= '0;
        end
        S_SHIFT: begin
          // A stray SOB abandons the partial block; the offending word is dropped too.
          if (bad_mid) begin
            state    <= S_CLEAR;
            word_cnt <= '0;
          end else if (good) begin
            if (word_cnt == LAST_WORD) begin
              state    <= S_DRAIN1;
              word_cnt <= '0;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end
        S_DRAIN1: state <= S_DRAIN2;
        S_DRAIN2: begin
          par_data <= lfsr_shift_reg;
          state    <= S_DONE;
        end
        S_DONE: if (par_ready) state <= S_CLEAR;
        default: state <= S_CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_jesd204_fec_block_feeder.sv
// Bench for jesd204_fec_block_feeder: behavioural LFSR stub on the shift port and a
// bit-serial long-division reference for the block parity.
module tb_jesd204_fec_block_feeder;
  logic        clk = 1'b0, resetn = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_sob = 1'b0, in_valid = 1'b0, in_ready;
  logic [25:0] par_data;
  logic        par_valid, par_ready = 1'b1;
  logic        sob_err, lfsr_rst, lfsr_shift_en;
  logic [5:0]  lfsr_shift_cnt;
  logic [63:0] lfsr_data_in;
  logic [25:0] lfsr_shift_reg;

  int  total = 0, bad = 0;
  int  sob_cnt = 0, pv_cycles = 0;
  time t_pv = 0;

  jesd204_fec_block_feeder dut (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_sob(in_sob), .in_valid(in_valid),
    .in_ready(in_ready), .par_data(par_data), .par_valid(par_valid), .par_ready(par_ready),
    .sob_err(sob_err), .lfsr_rst(lfsr_rst), .lfsr_shift_en(lfsr_shift_en),
    .lfsr_shift_cnt(lfsr_shift_cnt), .lfsr_data_in(lfsr_data_in),
    .lfsr_shift_reg(lfsr_shift_reg)
  );

  always #5 clk = ~clk;

  // LFSR stub: Galois register, s[i] = coefficient of x^i; index 26-i (port bit 25-i) holds S_i.
  logic [25:0] lfsr_s;
  function automatic logic [25:0] lfsr_step(input logic [25:0] s, input logic [63:0] d, input int n);
    for (int b = 0; b < n; b++)
      s = {s[24:0], 1'b0} ^ ({26{s[25] ^ d[b]}} & 26'h0220211);
    return s;
  endfunction
  function automatic logic [25:0] rev26(input logic [25:0] v);
    logic [25:0] r;
    for (int k = 0; k < 26; k++) r[25-k] = v[k];
    return r;
  endfunction
  always @(posedge clk)
    if (lfsr_rst) lfsr_s <= '0;
    else if (lfsr_shift_en) lfsr_s <= lfsr_step(lfsr_s, lfsr_data_in, int'(lfsr_shift_cnt) + 1);
  assign lfsr_shift_reg = rev26(lfsr_s);

  always @(negedge clk) begin
    if (sob_err)   sob_cnt   <= sob_cnt + 1;
    if (par_valid) pv_cycles <= pv_cycles + 1;
  end

  // Reference: remainder of M(x)*x^26 mod g(x), message bits fed MSb-first.
  function automatic logic [25:0] ref_parity(input logic [2047:0] m);
    logic [26:0] r;
    r = '0;
    for (int i = 2047; i >= -26; i--) begin
      r = {r[25:0], (i >= 0) ? m[i] : 1'b0};
      if (r[26]) r = r ^ 27'h4220211;
    end
    return rev26(r[25:0]);
  endfunction

  function automatic logic [2047:0] rand_blk();
    logic [2047:0] m;
    for (int w = 0; w < 32; w++) m[2047-64*w -: 64] = {$urandom, $urandom};
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [63:0] d, input bit sob, input int gap);
    bit ok;
    int n;
    in_valid = 1'b0;
    if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
    in_data = d; in_sob = sob; in_valid = 1'b1; ok = 1'b0; n = 0;
    while (!ok && n < 200) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0; in_sob = 1'b0;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_block(input logic [2047:0] m, input int maxgap);
    for (int w = 0; w < 32; w++)
      send_word(m[2047-64*w -: 64], w == 0, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  // Called one step after the final accept edge E0.
  task automatic wait_parity(input logic [25:0] exp, input string tag, input int stall,
                             input bit chk_clear, output logic [25:0] obs);
    @(negedge clk);
    chk({tag, "_lat0_pv"}, par_valid, 0);
    chk({tag, "_lat0_sen"}, lfsr_shift_en, 1);
    @(negedge clk);
    chk({tag, "_lat1_pv"}, par_valid, 0);
    @(negedge clk);
    chk({tag, "_lat2_pv"}, par_valid, 1);
    chk({tag, "_parity"}, par_data, exp);
    chk({tag, "_done_rdy"}, in_ready, 0);
    t_pv = $time;
    obs = par_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_stall_pv"}, par_valid, 1);
      chk({tag, "_stall_pd"}, par_data, exp);
      chk({tag, "_stall_rdy"}, in_ready, 0);
    end
    par_ready = 1'b1;
    @(posedge clk); #1;
    if (chk_clear) begin
      @(negedge clk);
      chk({tag, "_clr_rdy"}, in_ready, 0);
      chk({tag, "_clr_rst"}, lfsr_rst, 1);
      chk({tag, "_clr_pv"}, par_valid, 0);
      @(negedge clk);
      chk({tag, "_go_rdy"}, in_ready, 1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2047:0] ma, mb, mc;
    logic [25:0]   oa, ob, oc;
    int            s0, p0;
    time           t_prev;

    repeat (3) @(posedge clk); #1;
    chk("rst_rdy", in_ready, 0);
    chk("rst_lrst", lfsr_rst, 1);
    chk("rst_pv", par_valid, 0);
    chk("rst_pd", par_data, 0);
    chk("rst_serr", sob_err, 0);
    chk("rst_sen", lfsr_shift_en, 0);
    chk("rst_din", lfsr_data_in, 0);
    chk("shift_cnt", lfsr_shift_cnt, 63);
    resetn = 1'b1;
    @(negedge clk);
    chk("rel_rdy0", in_ready, 0);
    chk("rel_lrst1", lfsr_rst, 1);
    @(negedge clk);
    chk("rel_rdy1", in_ready, 1);
    chk("rel_lrst0", lfsr_rst, 0);
    @(posedge clk); #1;

    // zero block
    s0 = sob_cnt;
    ma = '0;
    send_block(ma, 0);
    wait_parity(ref_parity(ma), "zero", 0, 1, oa);
    chk("zero_const", oa, 26'h0);
    chk("zero_sob", sob_cnt, s0);

    // single leading bit
    ma = '0; ma[2047] = 1'b1;
    send_block(ma, 0);
    wait_parity(ref_parity(ma), "onebit", 0, 1, oa);

    // random blocks and linearity
    ma = rand_blk(); mb = rand_blk(); mc = ma ^ mb;
    send_block(ma, 0); wait_parity(ref_parity(ma), "randA", 0, 1, oa);
    send_block(mb, 0); wait_parity(ref_parity(mb), "randB", 0, 1, ob);
    send_block(mc, 0); wait_parity(ref_parity(mc), "randAB", 0, 1, oc);
    chk("linearity", oc, oa ^ ob);

    // back-pressure: input gaps plus a 10-cycle parity stall
    ma = rand_blk();
    send_block(ma, 0); wait_parity(ref_parity(ma), "bp_ref", 0, 1, oa);
    par_ready = 1'b0;
    send_block(ma, 3); wait_parity(ref_parity(ma), "bp", 10, 1, ob);
    chk("bp_same", ob, oa);

    // stray SOB on word 5
    s0 = sob_cnt; p0 = pv_cycles;
    ma = rand_blk(); mb = rand_blk();
    for (int w = 0; w < 5; w++) send_word(ma[2047-64*w -: 64], w == 0, 0);
    send_word(ma[2047-320 -: 64], 1'b1, 0);
    @(negedge clk);
    chk("f5_serr", sob_err, 1);
    chk("f5_sen", lfsr_shift_en, 0);
    @(posedge clk); #1;
    send_block(mb, 0);
    chk("f5_nopv", pv_cycles, p0);
    chk("f5_sobcnt", sob_cnt, s0 + 1);
    wait_parity(ref_parity(mb), "f5", 0, 1, oa);

    // missing SOB on first word
    s0 = sob_cnt;
    send_word({$urandom, $urandom}, 1'b0, 0);
    @(negedge clk);
    chk("f0_serr", sob_err, 1);
    chk("f0_sen", lfsr_shift_en, 0);
    @(posedge clk); #1;
    ma = rand_blk();
    send_block(ma, 0);
    wait_parity(ref_parity(ma), "f0", 0, 1, oa);
    chk("f0_sobcnt", sob_cnt, s0 + 1);

    // reset after word 17
    ma = rand_blk();
    for (int w = 0; w < 18; w++) send_word(ma[2047-64*w -: 64], w == 0, 0);
    resetn = 1'b0;
    #1;
    chk("mrst_rdy", in_ready, 0);
    chk("mrst_lrst", lfsr_rst, 1);
    chk("mrst_pv", par_valid, 0);
    chk("mrst_pd", par_data, 0);
    chk("mrst_sen", lfsr_shift_en, 0);
    chk("mrst_din", lfsr_data_in, 0);
    chk("mrst_serr", sob_err, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("mrel_lrst1", lfsr_rst, 1);
    chk("mrel_rdy0", in_ready, 0);
    @(negedge clk);
    chk("mrel_lrst0", lfsr_rst, 0);
    chk("mrel_rdy1", in_ready, 1);
    @(posedge clk); #1;
    mb = rand_blk();
    send_block(mb, 0);
    wait_parity(ref_parity(mb), "mrst", 0, 1, oa);

    // back-to-back throughput
    t_prev = 0;
    for (int b = 0; b < 4; b++) begin
      ma = rand_blk();
      send_block(ma, 0);
      wait_parity(ref_parity(ma), "tp", 0, 0, oa);
      if (b > 0) chk("tp_period", t_pv - t_prev, 360);
      t_prev = t_pv;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
